// File: rtl/ssp_uart_top.sv
`default_nettype none
// ============================================================================
// Module  : ssp_uart_top
// Brief   : 8-bit UART behind a 12-bit SSP register slave (UCR/USR/TDR/RDR/BRR)
// Rev     : 1.0  initial release
// ============================================================================
module ssp_uart_top #(
  parameter logic [11:0] BRR_RST = 12'd15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        SSP_SCK,
  input  logic        SSP_SSEL,
  input  logic        SSP_WnR,
  input  logic        SSP_EOC,
  input  logic [2:0]  SSP_RA,
  input  logic [11:0] SSP_DI,
  output logic [11:0] SSP_DO,
  input  logic        RxD,
  output logic        TxD,
  output logic        IRQ
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  logic [11:0] ucr_q, ucr_d, brr_q, brr_d;
  logic [7:0]  thr_q, thr_d;
  logic        thr_full_q, thr_full_d;
  uart_state_e tx_state_q, tx_state_d;
  logic [11:0] tx_cnt_q, tx_cnt_d, tx_len_q, tx_len_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_par_q, tx_par_d, txd_q, txd_d;
  uart_state_e rx_state_q, rx_state_d;
  logic [11:0] rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic        rx_par_q, rx_par_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_rdy_q, rx_rdy_d, ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic        irq_q, irq_d;

  logic        unused_sck;
  logic        wr_cmt, rd_usr, rd_rdr, par_en, par_even, rx_in, rx_fall;
  logic        tx_tick, rx_tick, rx_par_exp;
  logic [11:0] rx_half, usr;

  assign unused_sck = SSP_SCK;
  assign wr_cmt     = SSP_SSEL & SSP_EOC & SSP_WnR;
  assign rd_usr     = SSP_SSEL & SSP_EOC & ~SSP_WnR & (SSP_RA == 3'd1);
  assign rd_rdr     = SSP_SSEL & SSP_EOC & ~SSP_WnR & (SSP_RA == 3'd3);
  assign par_en     = ucr_q[3] ^ ucr_q[2];
  assign par_even   = ucr_q[3];
  assign rx_in      = ucr_q[7] ? txd_q : RxD;
  assign rx_fall    = rx_prev_q & ~rx_s2_q;
  assign tx_tick    = (tx_cnt_q == tx_len_q);
  assign rx_tick    = (rx_cnt_q == rx_len_q);
  assign rx_half    = 12'(({1'b0, rx_len_q} + 13'd1) >> 1);
  assign rx_par_exp = par_even ? ^rx_shift_q : ~^rx_shift_q;
  assign usr        = {6'h00, perr_q, ferr_q, ovr_q, rx_rdy_q, ~thr_full_q,
                       (tx_state_q != ST_IDLE)};
  assign TxD        = txd_q;
  assign IRQ        = irq_q;

  always_comb begin
    SSP_DO = 12'h000;
    if (SSP_SSEL && !SSP_WnR) begin
      case (SSP_RA)
        3'd0:    SSP_DO = ucr_q;
        3'd1:    SSP_DO = usr;
        3'd3:    SSP_DO = {4'h0, rx_byte_q};
        3'd4:    SSP_DO = brr_q;
        default: SSP_DO = 12'h000;
      endcase
    end
  end

  always_comb begin
    ucr_d = ucr_q;  brr_d = brr_q;  thr_d = thr_q;  thr_full_d = thr_full_q;
    tx_state_d = tx_state_q;  tx_cnt_d = tx_cnt_q;  tx_len_d = tx_len_q;
    tx_bit_d = tx_bit_q;  tx_shift_d = tx_shift_q;  tx_par_d = tx_par_q;  txd_d = txd_q;
    rx_state_d = rx_state_q;  rx_cnt_d = rx_cnt_q;  rx_len_d = rx_len_q;
    rx_bit_d = rx_bit_q;  rx_shift_d = rx_shift_q;  rx_byte_d = rx_byte_q;  rx_par_d = rx_par_q;
    rx_rdy_d = rx_rdy_q;  ovr_d = ovr_q;  ferr_d = ferr_q;  perr_d = perr_q;

    if (wr_cmt) begin
      case (SSP_RA)
        3'd0: ucr_d = SSP_DI;
        3'd2: if (!thr_full_q) begin thr_d = SSP_DI[7:0]; thr_full_d = 1'b1; end
        3'd4: brr_d = SSP_DI;
        default: ;
      endcase
    end
    if (rd_usr) begin ovr_d = 1'b0; ferr_d = 1'b0; perr_d = 1'b0; end
    if (rd_rdr) rx_rdy_d = 1'b0;

    // Bit length is latched at each boundary so BRR writes never stretch the current bit.
    if (tx_state_q != ST_IDLE) begin
      tx_cnt_d = tx_tick ? 12'd0 : tx_cnt_q + 12'd1;
      tx_len_d = tx_tick ? brr_q : tx_len_q;
    end
    case (tx_state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (ucr_q[0] && thr_full_q) begin
          tx_shift_d = thr_q;
          tx_par_d   = par_even ? ^thr_q : ~^thr_q;
          thr_full_d = 1'b0;
          tx_state_d = ST_START;
          tx_cnt_d   = 12'd0;
          tx_len_d   = brr_q;
          txd_d      = 1'b0;
        end
      end
      ST_START: if (tx_tick) begin
        tx_state_d = ST_DATA;  tx_bit_d = 3'd0;  txd_d = tx_shift_q[0];
      end
      ST_DATA: if (tx_tick) begin
        if (tx_bit_q == 3'd7) begin
          tx_bit_d = 3'd0;
          if (par_en) begin tx_state_d = ST_PAR;  txd_d = tx_par_q; end
          else        begin tx_state_d = ST_STOP; txd_d = 1'b1;     end
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          txd_d      = tx_shift_q[1];
        end
      end
      ST_PAR: if (tx_tick) begin tx_state_d = ST_STOP; txd_d = 1'b1; end
      ST_STOP: if (tx_tick) begin
        if (ucr_q[4] && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
        else                              tx_state_d = ST_IDLE;
      end
      default: tx_state_d = ST_IDLE;
    endcase

    if (rx_state_q != ST_IDLE) rx_cnt_d = rx_cnt_q + 12'd1;
    case (rx_state_q)
      ST_IDLE: if (ucr_q[1] && rx_fall) begin
        // The fall is seen one cycle into the start bit, so the count starts at 1.
        rx_state_d = ST_START;  rx_cnt_d = 12'd1;  rx_len_d = brr_q;
      end
      ST_START: if (rx_cnt_q >= rx_half) begin
        rx_cnt_d = 12'd0;  rx_len_d = brr_q;  rx_bit_d = 3'd0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_tick) begin
        rx_cnt_d   = 12'd0;  rx_len_d = brr_q;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = par_en ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (rx_tick) begin
        rx_cnt_d = 12'd0;  rx_len_d = brr_q;  rx_par_d = rx_s2_q;  rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_tick) begin
        rx_state_d = ST_IDLE;
        if (rx_rdy_d) ovr_d = 1'b1;
        else begin rx_byte_d = rx_shift_q; rx_rdy_d = 1'b1; end
        if (!rx_s2_q) ferr_d = 1'b1;
        if (par_en && (rx_par_q != rx_par_exp)) perr_d = 1'b1;
      end
      default: rx_state_d = ST_IDLE;
    endcase

    irq_d = (ucr_d[5] & rx_rdy_d) | (ucr_d[6] & ~thr_full_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ucr_q <= 12'h000;  brr_q <= BRR_RST;  thr_q <= 8'h00;  thr_full_q <= 1'b0;
      tx_state_q <= ST_IDLE;  tx_cnt_q <= 12'd0;  tx_len_q <= 12'd0;  tx_bit_q <= 3'd0;
      tx_shift_q <= 8'h00;  tx_par_q <= 1'b0;  txd_q <= 1'b1;
      rx_state_q <= ST_IDLE;  rx_cnt_q <= 12'd0;  rx_len_q <= 12'd0;  rx_bit_q <= 3'd0;
      rx_shift_q <= 8'h00;  rx_byte_q <= 8'h00;  rx_par_q <= 1'b0;
      rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
      rx_rdy_q <= 1'b0;  ovr_q <= 1'b0;  ferr_q <= 1'b0;  perr_q <= 1'b0;  irq_q <= 1'b0;
    end else begin
      ucr_q <= ucr_d;  brr_q <= brr_d;  thr_q <= thr_d;  thr_full_q <= thr_full_d;
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_len_q <= tx_len_d;  tx_bit_q <= tx_bit_d;
      tx_shift_q <= tx_shift_d;  tx_par_q <= tx_par_d;  txd_q <= txd_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_len_q <= rx_len_d;  rx_bit_q <= rx_bit_d;
      rx_shift_q <= rx_shift_d;  rx_byte_q <= rx_byte_d;  rx_par_q <= rx_par_d;
      rx_s1_q <= rx_in;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
      rx_rdy_q <= rx_rdy_d;  ovr_q <= ovr_d;  ferr_q <= ferr_d;  perr_q <= perr_d;  irq_q <= irq_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ssp_uart_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_ssp_uart_top
// Brief   : scoreboard bench for ssp_uart_top (register, Tx, Rx, error paths)
// Rev     : 1.0  initial release
// ============================================================================
module tb_ssp_uart_top;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        SSP_SSEL = 1'b0, SSP_WnR = 1'b0, SSP_EOC = 1'b0;
  logic [2:0]  SSP_RA = 3'd0;
  logic [11:0] SSP_DI = 12'h000;
  logic [11:0] SSP_DO;
  logic        RxD = 1'b1;
  logic        TxD, IRQ;

  ssp_uart_top #(.BRR_RST(12'd15)) dut (
    .Clk(Clk), .Rst(Rst), .SSP_SCK(Clk), .SSP_SSEL(SSP_SSEL), .SSP_WnR(SSP_WnR),
    .SSP_EOC(SSP_EOC), .SSP_RA(SSP_RA), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO),
    .RxD(RxD), .TxD(TxD), .IRQ(IRQ)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int          sel;    // 0: SSP_DO, 1: TxD, 2: IRQ
    logic [11:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [11:0] mon_act;
  logic        probe_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Monitor: a read strobe or a probe request consumes one expectation.
  always @(negedge Clk) begin
    if ((SSP_SSEL && SSP_EOC && !SSP_WnR) || probe_en) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: DUT output seen with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.sel)
          1:       mon_act = {11'h000, TxD};
          2:       mon_act = {11'h000, IRQ};
          default: mon_act = SSP_DO;
        endcase
        if (mon_act !== mon_e.exp) begin
          n_bad++;
          $display("FAIL %s: got 12'h%03h expected 12'h%03h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic push(input string nm, input int sel, input logic [11:0] exp);
    exp_t e;
    e.name = nm; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic ssp_write(input logic [2:0] ra, input logic [11:0] d);
    @(posedge Clk); #1;
    SSP_SSEL = 1'b1; SSP_WnR = 1'b1; SSP_EOC = 1'b1; SSP_RA = ra; SSP_DI = d;
    @(posedge Clk); #1;
    SSP_SSEL = 1'b0; SSP_WnR = 1'b0; SSP_EOC = 1'b0;
  endtask

  task automatic ssp_read(input logic [2:0] ra, input logic [11:0] exp, input string nm);
    @(posedge Clk); #1;
    push(nm, 0, exp);
    SSP_SSEL = 1'b1; SSP_WnR = 1'b0; SSP_EOC = 1'b1; SSP_RA = ra;
    @(posedge Clk); #1;
    SSP_SSEL = 1'b0; SSP_EOC = 1'b0;
  endtask

  task automatic probe(input int sel, input logic exp, input string nm);
    @(posedge Clk); #1;
    push(nm, sel, {11'h000, exp});
    probe_en = 1'b1;
    @(posedge Clk); #1;
    probe_en = 1'b0;
  endtask

  // Called right after a TDR write commit; samples the first cycle of each bit.
  task automatic check_frame(input logic [10:0] bits, input int nbits, input string nm);
    for (int k = 0; k < nbits; k++) begin
      probe(1, bits[k], $sformatf("%s_bit%0d", nm, k));
      repeat (2) @(posedge Clk);
    end
  endtask

  task automatic send_rx(input logic [10:0] bits, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      @(posedge Clk); #1 RxD = bits[k];
      repeat (3) @(posedge Clk);
    end
    @(posedge Clk); #1 RxD = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #50 Rst = 1'b0;

    // Reset state
    probe(1, 1'b1, "rst_txd");
    probe(2, 1'b0, "rst_irq");
    ssp_read(3'd1, 12'h002, "rst_usr");
    ssp_read(3'd4, 12'h00F, "rst_brr");
    ssp_read(3'd0, 12'h000, "rst_ucr");

    // UCR readback and TxEmpty interrupt
    ssp_write(3'd0, 12'hDED);
    ssp_read(3'd0, 12'hDED, "ucr_readback");
    probe(2, 1'b1, "irq_txempty");
    ssp_read(3'd5, 12'h000, "reserved_read");

    // Loopback 8N1 frame of 0xA5 at 4 clocks per bit
    ssp_write(3'd0, 12'h083);
    ssp_write(3'd4, 12'h003);
    ssp_read(3'd4, 12'h003, "brr_readback");
    ssp_write(3'd2, 12'h0A5);
    check_frame({1'b0, 1'b1, 8'hA5, 1'b0}, 10, "a5");
    repeat (12) @(posedge Clk);
    ssp_read(3'd1, 12'h006, "a5_usr_rxrdy");
    ssp_read(3'd3, 12'h0A5, "a5_rdr");
    ssp_read(3'd1, 12'h002, "a5_usr_clear");

    // Even parity, 0x07 has three ones so the parity bit is 1
    ssp_write(3'd0, 12'h08B);
    ssp_write(3'd2, 12'h007);
    check_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11, "par");
    repeat (12) @(posedge Clk);
    ssp_read(3'd1, 12'h006, "par_usr_noerr");
    ssp_read(3'd3, 12'h007, "par_rdr");
    ssp_read(3'd1, 12'h002, "par_usr_clear");

    // Pin frame with wrong parity and a low stop bit
    ssp_write(3'd0, 12'h00A);
    send_rx({1'b0, 1'b0, 8'h07, 1'b0}, 11);
    repeat (10) @(posedge Clk);
    ssp_read(3'd1, 12'h036, "err_usr");
    ssp_read(3'd1, 12'h006, "err_usr_cleared");
    ssp_read(3'd3, 12'h007, "err_rdr");
    ssp_read(3'd1, 12'h002, "err_usr_idle");

    // Overrun: two loopback frames without reading RDR
    ssp_write(3'd0, 12'h0A3);
    ssp_write(3'd2, 12'h03C);
    ssp_write(3'd2, 12'h05A);
    repeat (110) @(posedge Clk);
    probe(2, 1'b1, "ovr_irq_rxrdy");
    ssp_read(3'd1, 12'h00E, "ovr_usr");
    ssp_read(3'd3, 12'h03C, "ovr_rdr_first");
    probe(2, 1'b0, "ovr_irq_clear");
    ssp_read(3'd1, 12'h002, "ovr_usr_clear");

    // Reset in the middle of a frame with the holding register full
    ssp_write(3'd2, 12'h000);
    @(posedge Clk);
    repeat (8) @(posedge Clk);
    probe(1, 1'b0, "mid_txd_low");
    ssp_write(3'd2, 12'h055);
    ssp_read(3'd1, 12'h001, "mid_usr_busy_full");
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    probe(1, 1'b1, "mrst_txd");
    probe(2, 1'b0, "mrst_irq");
    ssp_read(3'd1, 12'h002, "mrst_usr");
    ssp_read(3'd0, 12'h000, "mrst_ucr");
    ssp_read(3'd4, 12'h00F, "mrst_brr");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge Clk);
    while (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no output expected 12'h%03h", mon_e.name, mon_e.exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
